// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite blit scheduler.
//   SPR_W/SPR_H/SPR_PIXELS : sprite geometry (30x30, 900 pixels)
//   SCREEN_W/SCREEN_H      : visible frame-buffer area
//   TRANSP_IDX             : palette index that is never written
//   blit_state_t           : blit FSM states
//   pix_idx_t              : sprite ROM pixel index
package sprite_pkg;

    localparam int SPR_W      = 30;
    localparam int SPR_H      = 30;
    localparam int SPR_PIXELS = SPR_W * SPR_H;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam logic [7:0] TRANSP_IDX = 8'h2b;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } blit_state_t;

    typedef logic [9:0] pix_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i        : request vector
//   last_grant_i : index of the most recently served requester
//   pick_o       : one-hot winner, the first set request after last_grant_i
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [LGW-1:0]  last_grant_i,
    output logic [NREQ-1:0] pick_o
);

    logic           found;
    logic [LGW-1:0] idx;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = LGW'((int'(last_grant_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_blit_sched.sv
// Sprite blit scheduler: grants one requester at a time, walks its sprite
// ROM row-major, drops transparent and off-screen pixels, and pushes the
// remaining pixels to the frame buffer over a valid/ready write port.
//   clk_i, reset_n_i        : clock, async active-low reset
//   req_i, req_x_i, req_y_i : level requests and sprite top-left positions
//   grant_o, done_o, busy_o : accept / completion pulses, activity flag
//   rom_sel_o, rom_addr_o, rom_data_i : sprite ROM read (combinational data)
//   fb_we_o, fb_addr_o, fb_data_o, fb_ready_i : frame-buffer write port
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch position
// FETCH | look at the current ROM pixel; skip it or stage a write
// WRITE | hold the write until the frame buffer accepts it
// DONE  | pulse done for the served requester, update round-robin pointer
module sprite_blit_sched
    import sprite_pkg::*;
#(
    parameter int         NREQ     = 2,
    parameter int         SPR_W    = sprite_pkg::SPR_W,
    parameter int         SPR_H    = sprite_pkg::SPR_H,
    parameter int         SCREEN_W = sprite_pkg::SCREEN_W,
    parameter int         SCREEN_H = sprite_pkg::SCREEN_H,
    parameter int         FB_AW    = 19,
    parameter logic [7:0] TRANSP   = TRANSP_IDX,
    parameter int         LGW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*10-1:0]   req_x_i,
    input  logic [NREQ*10-1:0]   req_y_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 busy_o,
    output logic [LGW-1:0]       rom_sel_o,
    output logic [9:0]           rom_addr_o,
    input  logic [7:0]           rom_data_i,
    output logic                 fb_we_o,
    output logic [FB_AW-1:0]     fb_addr_o,
    output logic [7:0]           fb_data_o,
    input  logic                 fb_ready_i
);

    localparam int CW   = $clog2(SPR_W);
    localparam int RW   = $clog2(SPR_H);
    localparam int NPIX = SPR_W * SPR_H;

    blit_state_t      state_q, state_d;
    logic [LGW-1:0]   last_grant_q, last_grant_d;
    logic [LGW-1:0]   rom_sel_q, rom_sel_d;
    logic [9:0]       x0_q, x0_d, y0_q, y0_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    pix_idx_t         pix_q, pix_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]       fb_data_q, fb_data_d;
    // Low until the first clock after reset so grant stays 0 while in reset.
    logic             run_q;

    logic [NREQ-1:0]  pick;
    logic [LGW-1:0]   pick_idx;
    logic [10:0]      sx, sy;
    logic             visible;
    logic             adv;

    rr_arbiter #(.NREQ(NREQ), .LGW(LGW)) u_arb (
        .req_i        (req_i),
        .last_grant_i (last_grant_q),
        .pick_o       (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = LGW'(i);
        end
    end

    assign sx      = {1'b0, x0_q} + 11'(col_q);
    assign sy      = {1'b0, y0_q} + 11'(row_q);
    assign visible = (rom_data_i != TRANSP) && (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rom_sel_d    = rom_sel_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        col_d        = col_q;
        row_d        = row_q;
        pix_d        = pix_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        adv          = 1'b0;
        grant_o      = '0;
        done_o       = '0;

        case (state_q)
            IDLE: begin
                if (run_q && (|pick)) begin
                    grant_o   = pick;
                    x0_d      = req_x_i[pick_idx*10 +: 10];
                    y0_d      = req_y_i[pick_idx*10 +: 10];
                    rom_sel_d = pick_idx;
                    col_d     = '0;
                    row_d     = '0;
                    pix_d     = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (visible) begin
                    // sy*640 built from shifts: 640 = 512 + 128
                    fb_addr_d = (FB_AW'(sy) << 9) + (FB_AW'(sy) << 7) + FB_AW'(sx);
                    fb_data_d = rom_data_i;
                    fb_we_d   = 1'b1;
                    state_d   = WRITE;
                end else begin
                    adv = 1'b1;
                end
            end
            WRITE: begin
                if (fb_ready_i) begin
                    fb_we_d = 1'b0;
                    adv     = 1'b1;
                end
            end
            DONE: begin
                done_o[rom_sel_q] = 1'b1;
                last_grant_d      = rom_sel_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (pix_q == pix_idx_t'(NPIX - 1)) begin
                state_d = DONE;
            end else begin
                state_d = FETCH;
                pix_d   = pix_q + 1'b1;
                if (col_q == CW'(SPR_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= LGW'(NREQ - 1);
            rom_sel_q    <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pix_q        <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rom_sel_q    <= rom_sel_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pix_q        <= pix_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            run_q        <= 1'b1;
        end
    end

    assign busy_o     = (state_q != IDLE) || (|grant_o);
    assign rom_sel_o  = rom_sel_q;
    assign rom_addr_o = pix_q;
    assign fb_we_o    = fb_we_q;
    assign fb_addr_o  = fb_addr_q;
    assign fb_data_o  = fb_data_q;

endmodule

// File: tb/tb_sprite_blit_sched.sv
module tb_sprite_blit_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [19:0] req_x, req_y;
    logic [1:0]  grant, done;
    logic        busy;
    logic        rom_sel;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ready;

    always #5 clk = ~clk;

    sprite_blit_sched #(.NREQ(2)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .req_i      (req),
        .req_x_i    (req_x),
        .req_y_i    (req_y),
        .grant_o    (grant),
        .done_o     (done),
        .busy_o     (busy),
        .rom_sel_o  (rom_sel),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .fb_we_o    (fb_we),
        .fb_addr_o  (fb_addr),
        .fb_data_o  (fb_data),
        .fb_ready_i (fb_ready)
    );

    // ROM modes: 0 = all 8'h05, 1 = all transparent, 2 = pokeB-like on rom 1
    int cur_mode, cur_sel, cur_x0, cur_y0;

    function automatic logic [7:0] poke_px(input int p);
        logic [7:0] v;
        if (p < 4) return 8'h2b;
        if (p == 4) return 8'h21;
        if (p % 5 == 0) return 8'h2b;
        v = 8'(p * 3);
        if (v == 8'h2b) v = 8'h2c;
        return v;
    endfunction

    function automatic logic [7:0] rom_fn(input int mode, input int sel, input int p);
        case (mode)
            0:       return 8'h05;
            1:       return 8'h2b;
            default: return (sel == 1) ? poke_px(p) : 8'h05;
        endcase
    endfunction

    always_comb rom_data = rom_fn(cur_mode, int'(rom_sel), int'(rom_addr));

    function automatic logic pixel_ok(input int addr, input logic [7:0] data,
                                      input int mode, input int sel, input int x0, input int y0);
        int sx, sy, px, py;
        if (addr >= 307200) return 1'b0;
        sx = addr % 640;
        sy = addr / 640;
        px = sx - x0;
        py = sy - y0;
        if (px < 0 || px > 29 || py < 0 || py > 29) return 1'b0;
        return data == rom_fn(mode, sel, py * 30 + px);
    endfunction

    // Monitor: samples at the falling edge, cleared by clr.
    logic clr;
    int cyc = 0;
    int wr_cnt = 0, we_cyc = 0, trans_wr = 0, bad_pix = 0;
    int first_addr = 0, first_data = 0, last_addr = 0;
    int grant_cnt = 0, done_cnt = 0, grant_val = 0, done_val = 0;
    int g_idx[8], g_cyc[8], d_cyc[8];

    always @(negedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            wr_cnt <= 0; we_cyc <= 0; trans_wr <= 0; bad_pix <= 0;
            first_addr <= 0; first_data <= 0; last_addr <= 0;
            grant_cnt <= 0; done_cnt <= 0; grant_val <= 0; done_val <= 0;
        end else begin
            if (|grant) begin
                if (grant_cnt < 8) begin
                    g_idx[grant_cnt] <= grant[1] ? 1 : 0;
                    g_cyc[grant_cnt] <= cyc;
                end
                grant_cnt <= grant_cnt + 1;
                grant_val <= int'(grant);
            end
            if (|done) begin
                if (done_cnt < 8) d_cyc[done_cnt] <= cyc;
                done_cnt <= done_cnt + 1;
                done_val <= int'(done);
            end
            if (fb_we) we_cyc <= we_cyc + 1;
            if (fb_we && fb_ready) begin
                if (wr_cnt == 0) begin
                    first_addr <= int'(fb_addr);
                    first_data <= int'(fb_data);
                end
                last_addr <= int'(fb_addr);
                wr_cnt    <= wr_cnt + 1;
                if (fb_data == 8'h2b) trans_wr <= trans_wr + 1;
                if (!pixel_ok(int'(fb_addr), fb_data, cur_mode, cur_sel, cur_x0, cur_y0))
                    bad_pix <= bad_pix + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic start_blit(input int r, input int x, input int y, input int mode);
        cur_mode = mode;
        cur_sel  = r;
        cur_x0   = x;
        cur_y0   = y;
        clear_mon();
        req_x[r*10 +: 10] = 10'(x);
        req_y[r*10 +: 10] = 10'(y);
        req = 2'(1 << r);
        for (int k = 0; k < 20 && grant_cnt == 0; k++) tick();
        req = 2'b00;
        check_val("grant_seen", grant_cnt, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && done_cnt < target; k++) tick();
    endtask

    int exp_poke;
    int stable;
    logic [18:0] a_s;
    logic [7:0]  d_s;
    logic [9:0]  ra_s;

    initial begin
        rst_n = 1'b0; req = 2'b11; req_x = '0; req_y = '0; fb_ready = 1'b1; clr = 1'b0;
        cur_mode = 1; cur_sel = 0; cur_x0 = 0; cur_y0 = 0;
        exp_poke = 0;
        for (int p = 0; p < 900; p++) if (poke_px(p) != 8'h2b) exp_poke++;

        // Reset values while req is already high
        clear_mon();
        repeat (2) tick();
        check_val("rst_grant", grant, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_fb_we", fb_we, 0);
        check_val("rst_fb_addr", fb_addr, 0);
        check_val("rst_rom_addr", rom_addr, 0);
        check_val("rst_rom_sel", rom_sel, 0);

        // Round robin with req=2'b11 held from reset, transparent ROMs
        rst_n = 1'b1;
        wait_done(4, 5000);
        req = 2'b00;
        repeat (3) tick();
        check_val("rr_done_cnt", done_cnt, 4);
        check_val("rr_grant_cnt", grant_cnt, 4);
        check_val("rr_g0", g_idx[0], 0);
        check_val("rr_g1", g_idx[1], 1);
        check_val("rr_g2", g_idx[2], 0);
        check_val("rr_g3", g_idx[3], 1);
        for (int k = 1; k < 4; k++) check_val("rr_after_done", g_cyc[k], d_cyc[k-1] + 1);
        check_val("rr_len", d_cyc[0] - g_cyc[0], 901);

        // pokeB-like ROM on requester 1
        start_blit(1, 0, 0, 2);
        wait_done(1, 3000);
        repeat (3) tick();
        check_val("pk_grant", grant_val, 2);
        check_val("pk_first_addr", first_addr, 4);
        check_val("pk_first_data", first_data, 8'h21);
        check_val("pk_transp_wr", trans_wr, 0);
        check_val("pk_writes", wr_cnt, exp_poke);
        check_val("pk_bad_pix", bad_pix, 0);
        check_val("pk_done_cnt", done_cnt, 1);
        check_val("pk_done_val", done_val, 2);

        // Opaque ROM at origin
        start_blit(0, 0, 0, 0);
        wait_done(1, 3000);
        check_val("op_writes", wr_cnt, 900);
        check_val("op_first_addr", first_addr, 0);
        check_val("op_last_addr", last_addr, 18589);
        check_val("op_len", d_cyc[0] - g_cyc[0], 1801);
        check_val("op_bad_pix", bad_pix, 0);
        check_val("op_done_val", done_val, 1);

        // All transparent
        start_blit(0, 0, 0, 1);
        wait_done(1, 2000);
        check_val("tr_we_cycles", we_cyc, 0);
        check_val("tr_len", d_cyc[0] - g_cyc[0], 901);

        // Clipping at the bottom-right corner
        start_blit(0, 620, 470, 0);
        wait_done(1, 3000);
        check_val("cl_writes", wr_cnt, 200);
        check_val("cl_first_addr", first_addr, 301420);
        check_val("cl_last_addr", last_addr, 307199);
        check_val("cl_bad_pix", bad_pix, 0);

        // Back-pressure on the first write
        fb_ready = 1'b0;
        start_blit(0, 0, 0, 0);
        for (int k = 0; k < 10 && fb_we !== 1'b1; k++) tick();
        a_s = fb_addr; d_s = fb_data; ra_s = rom_addr;
        stable = (fb_we === 1'b1) ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (fb_we === 1'b1 && fb_addr == a_s && fb_data == d_s && rom_addr == ra_s) stable++;
        end
        fb_ready = 1'b1;
        tick();
        check_val("st_stable_cycles", stable, 6);
        check_val("st_we_after", fb_we, 0);
        check_val("st_rom_addr_after", rom_addr, 1);
        wait_done(1, 3000);
        check_val("st_writes", wr_cnt, 900);

        // Reset in the middle of a blit
        start_blit(0, 0, 0, 0);
        for (int k = 0; k < 400 && wr_cnt < 100; k++) tick();
        for (int k = 0; k < 5 && fb_we !== 1'b1; k++) tick();
        check_val("mr_we_before", fb_we, 1);
        rst_n = 1'b0;
        #1;
        check_val("mr_fb_we", fb_we, 0);
        check_val("mr_busy", busy, 0);
        check_val("mr_rom_addr", rom_addr, 0);
        check_val("mr_fb_addr", fb_addr, 0);
        repeat (3) tick();
        check_val("mr_no_done", done_cnt, 0);
        check_val("mr_writes", wr_cnt, 100);
        rst_n = 1'b1;
        start_blit(0, 0, 0, 0);
        check_val("mr_restart_rom_addr", rom_addr, 0);
        wait_done(1, 3000);
        check_val("mr_restart_first", first_addr, 0);
        check_val("mr_restart_writes", wr_cnt, 900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blit_sched.md
Name: sprite_blit_sched

Overview:
- Schedules 30x30 sprite ROM blits into the frame buffer for up to NREQ requesters, e.g. player and enemy Pokemon sprites.
- Grants one requester at a time using round-robin arbitration.
- Walks the granted sprite ROM in row-major order and skips the transparent palette index.
- Clips pixels that fall off screen and issues valid/ready writes to the frame-buffer write port.
- Sits between game/scene logic and the sprite ROMs plus frame-buffer arbiter.

Parameters:
- NREQ, 2, number of requesters / sprite ROMs.
- SPR_W, 30, sprite width in pixels.
- SPR_H, 30, sprite height in pixels.
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- FB_AW, 19, frame-buffer address width.
- TRANSP, 8'h2b, palette index treated as transparent.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  level blit request per requester.
- req_x  in  NREQx10  sprite top-left X per requester; sampled only at grant.
- req_y  in  NREQx10  sprite top-left Y per requester; sampled only at grant.
- grant  out  NREQ  one-hot, one-cycle pulse when a request is accepted.
- done  out  NREQ  one-hot, one-cycle pulse when that requester's blit completes.
- busy  out  1  high from the grant cycle through the done cycle.
- rom_sel  out  $clog2(NREQ)  selects which sprite ROM drives rom_data.
- rom_addr  out  10  ROM pixel index, 0..SPR_W*SPR_H-1.
- rom_data  in  8  palette index from the selected ROM (combinational, same cycle).
- fb_we  out  1  write valid.
- fb_addr  out  FB_AW  write address, sy*SCREEN_W+sx.
- fb_data  out  8  palette index to write.
- fb_ready  in  1  frame buffer accepts the write this cycle.

Behaviour:
- Reset (asynchronous, effective immediately):
  - grant, done, busy, fb_we, fb_addr, fb_data, rom_addr, rom_sel all 0.
  - State IDLE; last_grant = NREQ-1, so requester 0 wins the first tie.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - If req!=0, the round-robin arbiter picks the first set bit after last_grant.
  - grant[i]=1 for that cycle; latch x0=req_x[i], y0=req_y[i], rom_sel=i; clear col, row and pix counter.
  - Next state FETCH. req is ignored outside IDLE.
- FETCH:
  - rom_addr = pix counter (incrementing counter, no multiplier).
  - sx = x0+col and sy = y0+row, each 11 bits.
  - Skip the pixel if rom_data==TRANSP, sx>=SCREEN_W or sy>=SCREEN_H; then advance and stay in FETCH.
  - Otherwise register fb_addr = (sy<<9)+(sy<<7)+sx and fb_data = rom_data, set fb_we=1, go to WRITE.
- WRITE:
  - fb_we, fb_addr and fb_data stay stable until the cycle with fb_ready=1.
  - That cycle is the transfer. Next cycle fb_we=0 and the pixel advances.
- Advance:
  - If pix == SPR_W*SPR_H-1, go to DONE.
  - Otherwise pix++ and col++. When col wraps from SPR_W-1 to 0, row++.
- DONE:
  - done[rom_sel]=1 for one cycle; last_grant = rom_sel; busy=0 from the next cycle; return to IDLE.
  - The earliest next grant is the cycle after DONE.
- A requester drops req on grant. If req is still high after done, it is served again as a new blit, subject to round-robin order.
- Timing:
  - Transparent or clipped pixel: 1 cycle.
  - Opaque pixel with fb_ready=1: 2 cycles.
  - Full opaque blit: 1 grant cycle + 1800 cycles + 1 done cycle.
- Reset mid-blit: the blit aborts with no done pulse and fb_we drops asynchronously. After reset, the first grant restarts at pixel 0.
- Changes to req_x, req_y or req during a blit have no effect on the blit in progress.

Decomposition:
- Package sprite_pkg holds:
  - Constants: SPR_W, SPR_H, SPR_PIXELS=900, TRANSP_IDX=8'h2b, SCREEN_W, SCREEN_H.
  - Typedef: blit_state_t enum (IDLE, FETCH, WRITE, DONE).
  - Typedef: pix_idx_t logic[9:0].
- Sub-module rr_arbiter (NREQ) takes req and last_grant and returns the one-hot pick; it is purely combinational.

Test Plan:
- Actual pokeB ROM as rom 1, req=2'b10, x=y=0, fb_ready=1 -> grant=2'b10.
  - First fb_we has fb_addr=4, fb_data=8'h21.
  - No write is issued for any 8'h2b pixel.
  - Exactly one done[1] pulse.
- ROM model returns 8'h05 everywhere, req0 at (0,0) -> 900 writes.
  - First fb_addr=0, last fb_addr=18589.
  - done[0] arrives exactly 1801 cycles after grant.
- All-8'h2b ROM -> zero fb_we cycles; done pulse 901 cycles after grant.
- Clipping, x=620, y=470, opaque ROM -> exactly 200 writes.
  - First fb_addr=301420; all writes have sx<640 and sy<480.
- req=2'b11 held from reset -> grants in order 0, 1, 0, 1; each grant occurs only after the previous done.
- fb_ready held low for 5 cycles on the first write -> fb_we/fb_addr/fb_data stable for 6 cycles and rom_addr does not advance.
- Reset_n low after 100 writes -> all outputs 0 immediately and no done pulse.
  - A new req0 then restarts at rom_addr=0.
